// File: rtl/condicionador_entradas.sv
// Input conditioning for the memory game: 2-FF synchronizers, per-channel debounce,
// single-button press FSM and start-button edge pulse. Macro CONDICIONADOR_DEBOUNCE_EN enables the debounce counters.
module condicionador_entradas #(
    parameter int N_DEBOUNCE = 50000,
    parameter int CONT_W     = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] botoes_brutos,
    input  logic       jogar_bruto,
    output logic [3:0] botoes,
    output logic       botao_pulso,
    output logic       jogar,
    output logic       multiplo,
    output logic [1:0] db_estado
);

    typedef enum logic [1:0] {
        LIVRE       = 2'd0,
        PRESSIONADO = 2'd1,
        INVALIDO    = 2'd2
    } estado_t;

    // Channel 4 is the start button; channels 3..0 are the colour buttons.
    logic [4:0] meta_reg;
    logic [4:0] sync_reg;
    logic [4:0] est;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= {jogar_bruto, botoes_brutos};
            sync_reg <= meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_db
            logic est_reg;
`ifdef CONDICIONADOR_DEBOUNCE_EN
            logic [CONT_W-1:0] cnt_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    est_reg <= 1'b0;
                    cnt_reg <= '0;
                end else if (sync_reg[gi] == est_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CONT_W'(N_DEBOUNCE - 1)) begin
                    est_reg <= sync_reg[gi];
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
`else
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    est_reg <= 1'b0;
                end else begin
                    est_reg <= sync_reg[gi];
                end
            end
`endif
            assign est[gi] = est_reg;
        end
    endgenerate

`ifndef CONDICIONADOR_DEBOUNCE_EN
    localparam int cfg_unused = N_DEBOUNCE + CONT_W;
`endif

    logic [3:0] est_b;
    logic       est_j;
    logic       one_hot;

    assign est_b   = est[3:0];
    assign est_j   = est[4];
    assign one_hot = (est_b != 4'd0) && ((est_b & (est_b - 4'd1)) == 4'd0);

    estado_t    state_reg, state_next;
    logic [3:0] latched_reg, latched_next;
    logic [3:0] botoes_reg, botoes_next;
    logic       pulso_reg, pulso_next;
    logic       multiplo_reg;
    logic       est_j_prev_reg;
    logic       jogar_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= LIVRE;
            latched_reg    <= '0;
            botoes_reg     <= '0;
            pulso_reg      <= 1'b0;
            multiplo_reg   <= 1'b0;
            est_j_prev_reg <= 1'b0;
            jogar_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            latched_reg    <= latched_next;
            botoes_reg     <= botoes_next;
            pulso_reg      <= pulso_next;
            multiplo_reg   <= (state_next == INVALIDO);
            est_j_prev_reg <= est_j;
            jogar_reg      <= est_j & ~est_j_prev_reg;
        end
    end

    always_comb begin
        state_next   = state_reg;
        latched_next = latched_reg;
        botoes_next  = botoes_reg;
        pulso_next   = 1'b0;
        case (state_reg)
            LIVRE: begin
                if (one_hot) begin
                    state_next   = PRESSIONADO;
                    latched_next = est_b;
                    botoes_next  = est_b;
                    pulso_next   = 1'b1;
                end else if (est_b != 4'd0) begin
                    state_next = INVALIDO;
                end
            end
            PRESSIONADO: begin
                if (est_b == 4'd0) begin
                    state_next  = LIVRE;
                    botoes_next = 4'd0;
                end else if (est_b != latched_reg) begin
                    // Any extra or swapped button voids the press until full release.
                    state_next  = INVALIDO;
                    botoes_next = 4'd0;
                end
            end
            INVALIDO: begin
                if (est_b == 4'd0) begin
                    state_next = LIVRE;
                end
            end
            default: begin
                state_next  = LIVRE;
                botoes_next = 4'd0;
            end
        endcase
    end

    assign botoes      = botoes_reg;
    assign botao_pulso = pulso_reg;
    assign jogar       = jogar_reg;
    assign multiplo    = multiplo_reg;
    assign db_estado   = state_reg;

endmodule

// File: tb/tb_condicionador_entradas.sv
// Scoreboard bench for condicionador_entradas: a window-based reference model predicts
// press/start pulses into queues; a negedge monitor pops and compares them.
module tb_condicionador_entradas;

    localparam int N = 4;
`ifdef CONDICIONADOR_DEBOUNCE_EN
    localparam int W = N;
`else
    localparam int W = 1;
`endif

    logic       clock;
    logic       reset;
    logic [3:0] botoes_brutos;
    logic       jogar_bruto;
    logic [3:0] botoes;
    logic       botao_pulso;
    logic       jogar;
    logic       multiplo;
    logic [1:0] db_estado;

    condicionador_entradas #(.N_DEBOUNCE(N), .CONT_W(16)) dut (
        .clock(clock),
        .reset(reset),
        .botoes_brutos(botoes_brutos),
        .jogar_bruto(jogar_bruto),
        .botoes(botoes),
        .botao_pulso(botao_pulso),
        .jogar(jogar),
        .multiplo(multiplo),
        .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_press = 0;
    int n_jogar = 0;

    typedef struct {
        int       cyc;
        bit [3:0] code;
    } ev_t;
    ev_t q_press[$];
    int  q_jogar[$];

    // Reference model state (spec terms: stable levels, game state code, latched button)
    bit [4:0] m_s1, m_sync, m_est;
    bit [4:0] m_hist[$];
    bit       m_est_j_prev;
    int       m_state;
    bit [3:0] m_latched, m_botoes;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: one step per clock edge, evaluated 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (reset) begin
                m_s1 = '0; m_sync = '0; m_est = '0; m_est_j_prev = 0;
                m_hist.delete();
                m_state = 0; m_latched = '0; m_botoes = '0;
            end else begin
                bit [3:0] eb;
                int pc;
                bit all_diff;
                eb = m_est[3:0];
                pc = $countones(eb);
                case (m_state)
                    0: if (pc == 1) begin
                           m_state = 1; m_latched = eb; m_botoes = eb;
                           q_press.push_back('{cyc, eb});
                       end else if (pc >= 2) m_state = 2;
                    1: if (eb == 4'd0) begin
                           m_state = 0; m_botoes = 0;
                       end else if (eb != m_latched) begin
                           m_state = 2; m_botoes = 0;
                       end
                    default: if (eb == 4'd0) m_state = 0;
                endcase
                if (m_est[4] && !m_est_j_prev) q_jogar.push_back(cyc);
                m_est_j_prev = m_est[4];
                // A level is accepted once the synchronized input has differed for W edges in a row.
                m_hist.push_back(m_sync);
                if (m_hist.size() > W) void'(m_hist.pop_front());
                if (m_hist.size() == W) begin
                    for (int c = 0; c < 5; c++) begin
                        all_diff = 1;
                        foreach (m_hist[i]) if (m_hist[i][c] == m_est[c]) all_diff = 0;
                        if (all_diff) m_est[c] = ~m_est[c];
                    end
                end
                m_sync = m_s1;
                m_s1 = {jogar_bruto, botoes_brutos};
            end
        end
    end

    // Monitor: compare levels every cycle, pop scoreboard on each DUT pulse.
    initial begin
        forever begin
            @(negedge clock);
            chk("botoes", botoes, reset ? 0 : int'(m_botoes));
            chk("multiplo", multiplo, reset ? 0 : int'(m_state == 2));
            chk("db_estado", db_estado, reset ? 0 : m_state);
            while (q_press.size() > 0 && q_press[0].cyc < cyc) begin
                chk("missed_press_pulse", 0, 1);
                void'(q_press.pop_front());
            end
            while (q_jogar.size() > 0 && q_jogar[0] < cyc) begin
                chk("missed_jogar_pulse", 0, 1);
                void'(q_jogar.pop_front());
            end
            if (botao_pulso) begin
                if (q_press.size() == 0) chk("unexpected_press_pulse", 1, 0);
                else begin
                    ev_t e;
                    e = q_press.pop_front();
                    chk("press_cycle", cyc, e.cyc);
                    chk("press_code", botoes, e.code);
                    n_press++;
                    $display("press pulse %0d: cycle=%0d code=%b", n_press, cyc, botoes);
                end
            end
            if (jogar) begin
                if (q_jogar.size() == 0) chk("unexpected_jogar_pulse", 1, 0);
                else begin
                    int ec;
                    ec = q_jogar.pop_front();
                    chk("jogar_cycle", cyc, ec);
                    n_jogar++;
                    $display("jogar pulse %0d: cycle=%0d", n_jogar, cyc);
                end
            end
        end
    end

    // Drive inputs at posedge+2 and hold for n edges; returns at posedge+2.
    task automatic hold(input logic [3:0] b, input logic j, input int n);
        botoes_brutos = b;
        jogar_bruto = j;
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    initial begin
        reset = 1'b1;
        botoes_brutos = 4'b0010;
        jogar_bruto = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #2;
        end
        chk("reset_botoes", botoes, 0);
        chk("reset_pulso", botao_pulso, 0);
        chk("reset_db_estado", db_estado, 0);
        reset = 1'b0;
        hold(4'b0010, 0, 12);
        hold(4'b0000, 0, 12);
        // bounce then steady press
        for (int i = 0; i < 3; i++) begin
            hold(4'b0100, 0, 1);
            hold(4'b0000, 0, 1);
        end
        hold(4'b0100, 0, 12);
        hold(4'b0000, 0, 12);
        // extra button voids the press
        hold(4'b0001, 0, 12);
        hold(4'b1001, 0, 12);
        hold(4'b0001, 0, 12);
        hold(4'b0000, 0, 12);
        // simultaneous press
        hold(4'b0011, 0, 12);
        hold(4'b0000, 0, 12);
        // start button: long press then short glitch
        hold(4'b0000, 1, 20);
        hold(4'b0000, 0, 10);
        hold(4'b0000, 1, 2);
        hold(4'b0000, 0, 12);
        // press and start together
        hold(4'b0100, 1, 12);
        hold(4'b0000, 0, 12);
        // asynchronous reset in the middle of a held press
        hold(4'b0001, 0, 12);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_botoes", botoes, 0);
        chk("async_reset_db_estado", db_estado, 0);
        chk("async_reset_multiplo", multiplo, 0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        hold(4'b0001, 0, 12);
        hold(4'b0000, 0, 12);
        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            int r;
            logic [3:0] b;
            r = $urandom_range(0, 9);
            if (r < 3) b = 4'b0000;
            else if (r < 7) b = 4'b0001 << $urandom_range(0, 3);
            else b = 4'($urandom_range(1, 15));
            hold(b, ($urandom_range(0, 3) == 0), $urandom_range(1, 10));
        end
        hold(4'b0000, 0, 15);
        @(negedge clock);
        chk("press_queue_drained", q_press.size(), 0);
        chk("jogar_queue_drained", q_jogar.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/condicionador_entradas.md
Name: condicionador_entradas

Overview:
Input-conditioning stage directly upstream of the memory-game top level; consumes raw board pushbuttons and drives the game's `botoes` and `jogar` inputs.
- Synchronizes and debounces 4 colour buttons plus the start button.
- Enforces single-button presses and emits clean one-cycle event pulses.
- Exposes debug state for the 7-seg/LED debug path.

Parameters:
N_DEBOUNCE, 50000, consecutive stable cycles required to accept a level change (1 ms at 50 MHz); must be >= 2.
CONT_W, 16, debounce counter width; must satisfy 2^CONT_W > N_DEBOUNCE.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
botoes_brutos  in  4  raw colour buttons, asynchronous, 1 = pressed
jogar_bruto  in  1  raw start button, asynchronous, 1 = pressed
botoes  out  4  conditioned buttons: one-hot while a valid press is held, else 0000
botao_pulso  out  1  one-cycle pulse on acceptance of a new valid press
jogar  out  1  one-cycle pulse on debounced rising edge of start button
multiplo  out  1  high while in INVALIDO (more than one button pressed)
db_estado  out  2  FSM state code: LIVRE=0, PRESSIONADO=1, INVALIDO=2

Behaviour:
Reset (async, active-high):
- Sync FFs, stable levels, counters and outputs cleared to 0.
- FSM goes to LIVRE.
Synchronizer:
- 2-FF chain per input (5 channels); the second FF is `sync`.
Debounce, independent per channel:
- Registers `est` (stable level) and `cnt`.
- If sync == est: cnt <= 0.
- Else if cnt == N_DEBOUNCE-1: est <= sync, cnt <= 0.
- Else: cnt <= cnt+1.
- Any bounce shorter than N_DEBOUNCE cycles restarts the count, so `est` does not change.
Latency:
- Input first sampled high at edge k: est rises after edge k+N_DEBOUNCE+1.
- Registered FSM outputs and pulses appear after edge k+N_DEBOUNCE+2.
- Release has the same latency.
FSM on est_b (4-bit stable colour vector); all outputs are registered:
- LIVRE: botoes = 0, multiplo = 0.
  - popcount(est_b) == 1 -> PRESSIONADO; latch est_b; botoes <= est_b; botao_pulso <= 1 for 1 cycle.
  - popcount(est_b) >= 2 -> INVALIDO; no pulse.
- PRESSIONADO: botoes holds the latched code.
  - est_b == latched -> stay.
  - est_b == 0 -> LIVRE; botoes <= 0.
  - Any other value (extra or different button) -> INVALIDO; botoes <= 0; no pulse.
- INVALIDO: botoes = 0, multiplo = 1.
  - est_b == 0 -> LIVRE.
  - Otherwise stay. No new press is accepted until a full release.
Start button:
- jogar <= est_j & ~est_j_prev: exactly one cycle per debounced press, independent of the FSM.
Simultaneous events:
- Two buttons stabilizing on the same edge count as popcount 2 -> INVALIDO.
- jogar and botao_pulso may pulse on the same cycle.
Reset mid-press:
- All state is cleared.
- A button still held after reset release re-passes sync + debounce and is accepted as a new press, pulsing once.
Width rule:
- cnt never exceeds N_DEBOUNCE-1; no wrap-around is reachable.

Optional Feature:
Macro: CONDICIONADOR_DEBOUNCE_EN.
- Defined: debounce counters active as above.
- Undefined: counters omitted; est = sync directly. Latency becomes pulse after edge k+3 and bounces pass through. Intended for fast game-level simulation only.

Test Plan:
Bench uses N_DEBOUNCE=4, macro defined.
1. Reset held, botoes_brutos=0010 -> all outputs 0, db_estado=0; release reset -> botoes=0010 and one botao_pulso after edge k+6 (k = first sampling edge after release), db_estado=1.
2. Press 0100 with 3-cycle bounce (1,0,1,0,1,0) then steady -> exactly one botao_pulso, botoes=0100 after edge (steady start)+6; release -> botoes=0000 six cycles later, db_estado=0.
3. Hold 0001 (accepted), then add 1000 -> botoes=0000, multiplo=1, db_estado=2, no pulse; release only 1000 -> stays INVALIDO; release all -> LIVRE, multiplo=0.
4. Press 0011 simultaneously -> INVALIDO directly, no pulse.
5. jogar_bruto high 20 cycles -> jogar high exactly 1 cycle, after edge k+6; 2-cycle glitch on jogar_bruto -> no pulse.
6. Assert reset asynchronously mid-cycle while in PRESSIONADO -> outputs 0 immediately, without waiting for a clock edge; macro undefined rebuild: press 0001 -> pulse after edge k+3.
